// File: rtl/coherence_pkg.sv
// Shared types for the two-cache snoop controller: line end states, FSM states, helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package coherence_pkg;

    localparam int BLOCK_SIZE_DEF = 2;
    localparam int NUM_CACHES     = 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } cc_end_state;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNOOP = 3'd1,
        WB    = 3'd2,
        FETCH = 3'd3,
        RESP  = 3'd4
    } fsm_state_t;

    // A write always ends Modified; a read shares with a peer that held the line, else owns it.
    function automatic cc_end_state resp_end_state(input logic write, input logic hit);
        if (write) begin
            return MODIFIED;
        end
        return hit ? SHARED : EXCLUSIVE;
    endfunction

endpackage

// File: rtl/coherence_snoop_ctrl_if.sv
// Cache coherence ports plus the word-serial memory port seen by the snoop controller.
// Latency: none (wiring only).
// Backpressure: requests held until resp_valid; snoops stall on snoop_busy; memory on mem_ready.
interface coherence_snoop_ctrl_if
    import coherence_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF
) ();

    // miss requests from the caches
    logic [NUM_CACHES-1:0]     req_valid;
    logic [NUM_CACHES-1:0]     req_write;
    word_t                     req_addr       [NUM_CACHES];

    // completion back to the requester
    logic [NUM_CACHES-1:0]     resp_valid;
    logic [32*BLOCK_SIZE-1:0]  resp_data      [NUM_CACHES];
    cc_end_state               resp_state     [NUM_CACHES];

    // snoop of the peer cache
    logic [NUM_CACHES-1:0]     snoop_req;
    word_t                     addr           [NUM_CACHES];
    cc_end_state               state_transfer [NUM_CACHES];
    logic [NUM_CACHES-1:0]     snoop_busy;
    logic [NUM_CACHES-1:0]     snoop_hit;
    logic [NUM_CACHES-1:0]     valid;
    logic [NUM_CACHES-1:0]     exclusive;
    logic [NUM_CACHES-1:0]     dirty;
    logic [NUM_CACHES-1:0]     dWEN;
    logic [32*BLOCK_SIZE-1:0]  requested_data [NUM_CACHES];

    // word-serial memory
    logic                      mem_ren;
    logic                      mem_wen;
    word_t                     mem_addr;
    word_t                     mem_wdata;
    word_t                     mem_rdata;
    logic                      mem_ready;

    modport master (
        input  req_valid, req_write, req_addr,
        output resp_valid, resp_data, resp_state,
        output snoop_req, addr, state_transfer,
        input  snoop_busy, snoop_hit, valid, exclusive, dirty, dWEN, requested_data,
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output req_valid, req_write, req_addr,
        input  resp_valid, resp_data, resp_state,
        input  snoop_req, addr, state_transfer,
        output snoop_busy, snoop_hit, valid, exclusive, dirty, dWEN, requested_data,
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/coherence_rr_arbiter.sv
// Two-requester round-robin arbiter; pointer moves past the served cache on advance.
// Latency: grant is combinational from req; pointer updates one edge after advance.
// Backpressure: losers keep requesting; nothing is dropped.
module coherence_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       served,
    output logic       grant_vld,
    output logic       grant_idx
);

    logic ptr;

    // favoured cache wins a tie, otherwise whichever cache is asking
    always_comb begin
        grant_vld = |req;
        grant_idx = req[ptr] ? ptr : ~ptr;
    end

    // after a completed request the other cache gets priority
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~served;
        end
    end

endmodule

// File: rtl/coherence_snoop_ctrl.sv
// Serves L1 misses: snoops the peer, then cache-to-cache, writeback of dirty data, or memory fetch.
// Latency: clean hit 2 cycles from request; +1 per snoop_busy cycle; +cycles-to-mem_ready per word.
// Backpressure: one transaction at a time; other requests wait in IDLE, strobes held until mem_ready.
module coherence_snoop_ctrl
    import coherence_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int N_CACHES   = NUM_CACHES
) (
    input  logic                  CLK,
    input  logic                  RST,
    coherence_snoop_ctrl_if.master bus
);

    localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int BW = 32 * BLOCK_SIZE;
    localparam word_t OFF_MASK = word_t'((1 << ($clog2(BLOCK_SIZE) + 2)) - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_SIZE - 1);

    typedef logic [$clog2(N_CACHES)-1:0] cache_idx_t;

    fsm_state_t     state;
    cache_idx_t     req_idx;
    cache_idx_t     peer;
    logic           lat_write;
    word_t          lat_addr;
    logic [BW-1:0]  block;
    logic [CW-1:0]  cnt;

    logic           grant_vld;
    logic           grant_idx;
    cache_idx_t     gnt_peer;
    word_t          base_addr;
    logic [CW-1:0]  cnt_nxt;
    word_t          word_addr_nxt;
    logic [BW-1:0]  fill_block;

    coherence_rr_arbiter u_arb (
        .clk       (CLK),
        .rst       (RST),
        .req       (bus.req_valid),
        .advance   (state == RESP),
        .served    (req_idx),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    assign gnt_peer      = ~grant_idx;
    assign base_addr     = lat_addr & ~OFF_MASK;
    assign cnt_nxt       = cnt + CW'(1);
    assign word_addr_nxt = base_addr + (word_t'(cnt_nxt) << 2);

    // block with the word currently returned by memory merged into its slot
    always_comb begin
        fill_block = block;
        fill_block[cnt*32 +: 32] = bus.mem_rdata;
    end

    // transaction FSM; every bus output is registered here
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            req_idx        <= '0;
            peer           <= '0;
            lat_write      <= 1'b0;
            lat_addr       <= '0;
            block          <= '0;
            cnt            <= '0;
            bus.resp_valid <= '0;
            bus.snoop_req  <= '0;
            bus.mem_ren    <= 1'b0;
            bus.mem_wen    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            for (int i = 0; i < N_CACHES; i++) begin
                bus.addr[i]           <= '0;
                bus.state_transfer[i] <= INVALID;
                bus.resp_data[i]      <= '0;
                bus.resp_state[i]     <= INVALID;
            end
        end else begin
            bus.resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        req_idx                      <= grant_idx;
                        peer                         <= gnt_peer;
                        lat_write                    <= bus.req_write[grant_idx];
                        lat_addr                     <= bus.req_addr[grant_idx];
                        bus.snoop_req[gnt_peer]      <= 1'b1;
                        bus.addr[gnt_peer]           <= bus.req_addr[grant_idx];
                        bus.state_transfer[gnt_peer] <= bus.req_write[grant_idx] ? INVALID : SHARED;
                        state                        <= SNOOP;
                    end
                end
                SNOOP: begin
                    if (!bus.snoop_busy[peer]) begin
                        bus.snoop_req[peer] <= 1'b0;
                        block               <= bus.requested_data[peer];
                        cnt                 <= '0;
                        if (bus.snoop_hit[peer]) begin
                            if (bus.dirty[peer] | bus.dWEN[peer]) begin
                                // peer's copy is newer than memory: push it out first
                                bus.mem_wen   <= 1'b1;
                                bus.mem_addr  <= base_addr;
                                bus.mem_wdata <= bus.requested_data[peer][31:0];
                                state         <= WB;
                            end else begin
                                bus.resp_valid[req_idx] <= 1'b1;
                                bus.resp_data[req_idx]  <= bus.requested_data[peer];
                                bus.resp_state[req_idx] <= resp_end_state(lat_write, 1'b1);
                                state                   <= RESP;
                            end
                        end else begin
                            bus.mem_ren  <= 1'b1;
                            bus.mem_addr <= base_addr;
                            state        <= FETCH;
                        end
                    end
                end
                WB: begin
                    if (bus.mem_ready) begin
                        if (cnt == LAST_WORD) begin
                            bus.mem_wen             <= 1'b0;
                            cnt                     <= '0;
                            bus.resp_valid[req_idx] <= 1'b1;
                            bus.resp_data[req_idx]  <= block;
                            bus.resp_state[req_idx] <= resp_end_state(lat_write, 1'b1);
                            state                   <= RESP;
                        end else begin
                            cnt           <= cnt_nxt;
                            bus.mem_addr  <= word_addr_nxt;
                            bus.mem_wdata <= block[cnt_nxt*32 +: 32];
                        end
                    end
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        block <= fill_block;
                        if (cnt == LAST_WORD) begin
                            bus.mem_ren             <= 1'b0;
                            cnt                     <= '0;
                            bus.resp_valid[req_idx] <= 1'b1;
                            bus.resp_data[req_idx]  <= fill_block;
                            bus.resp_state[req_idx] <= resp_end_state(lat_write, 1'b0);
                            state                   <= RESP;
                        end else begin
                            cnt          <= cnt_nxt;
                            bus.mem_addr <= word_addr_nxt;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
